// File: rtl/partial_scheduler.sv
// Partial scheduler: sequences NUM_VOICES sine partials through one shared,
// pipelined CORDIC per sample frame and mixes the returned sines, each
// weighted by its voice gain, into one signed sum.
module partial_scheduler #(
   parameter int NUM_VOICES     = 8,
   parameter int CORDIC_LATENCY = 20
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  sample_tick,
   input  logic                                  cfg_we,
   input  logic [$clog2(NUM_VOICES)-1:0]         cfg_voice,
   input  logic [13:0]                           cfg_incr,
   input  logic [7:0]                            cfg_gain,
   output logic [13:0]                           cordic_angle,
   output logic                                  cordic_angle_valid,
   input  logic signed [15:0]                    cordic_sin,
   input  logic                                  cordic_valid,
   output logic signed [24+$clog2(NUM_VOICES)-1:0] mix_out,
   output logic                                  mix_valid,
   output logic                                  busy,
   output logic                                  overrun,
   input  logic                                  overrun_clr
);

   localparam int VW = $clog2(NUM_VOICES);
   localparam int MW = 24 + VW;
   localparam int FW = (CORDIC_LATENCY > 1) ? $clog2(CORDIC_LATENCY) : 1;

   typedef enum logic [1:0] {
      S_FLUSH,
      S_IDLE,
      S_ISSUE,
      S_COLLECT
   } state_t;

   state_t              r_state;
   logic [FW-1:0]       r_flush_cnt;
   logic [VW-1:0]       r_issue;
   logic [VW:0]         r_ret;
   logic signed [MW-1:0] r_acc;
   logic signed [MW-1:0] r_mix;
   logic                r_mix_valid;
   logic                r_done;
   logic                r_overrun;
   logic [13:0]         r_phase [NUM_VOICES];
   logic [13:0]         r_incr  [NUM_VOICES];
   logic [7:0]          r_gain  [NUM_VOICES];

   logic [13:0]         w_angle;
   logic                w_issuing;
   logic                w_in_frame;
   logic [VW-1:0]       w_ret_idx;
   logic                w_accept;
   logic                w_last;
   logic signed [23:0]  w_sin_ext;
   logic signed [23:0]  w_gain_ext;
   logic signed [23:0]  w_prod;
   logic signed [MW-1:0] w_prod_ext;

   // Angle for the voice being issued; the 14-bit sum wraps modulo 2^14,
   // which is exactly the +-pi wrap of the two's complement angle.
   assign w_angle    = r_phase[r_issue] + r_incr[r_issue];
   assign w_issuing  = (r_state == S_ISSUE);
   assign w_in_frame = (r_state == S_ISSUE) || (r_state == S_COLLECT);

   // Results come back in issue order, so the return counter names the voice.
   // Once all NUM_VOICES results are in, further strobes are ignored.
   assign w_ret_idx  = r_ret[VW-1:0];
   assign w_accept   = cordic_valid && w_in_frame &&
                       (r_ret != (VW+1)'(NUM_VOICES));
   assign w_last     = w_accept && (w_ret_idx == VW'(NUM_VOICES - 1));

   // Q2.14 sine times unsigned Q0.8 gain always fits a 24-bit signed product.
   assign w_sin_ext  = {{8{cordic_sin[15]}}, cordic_sin};
   assign w_gain_ext = {16'd0, r_gain[w_ret_idx]};
   assign w_prod     = w_sin_ext * w_gain_ext;
   assign w_prod_ext = {{VW{w_prod[23]}}, w_prod};

   assign cordic_angle       = w_issuing ? w_angle : 14'd0;
   assign cordic_angle_valid = w_issuing;
   assign busy               = (r_state != S_IDLE);
   assign mix_out            = r_mix;
   assign mix_valid          = r_mix_valid;
   assign overrun            = r_overrun;

   // Voice configuration: writable at any time, read only when issuing.
   always_ff @(posedge clk) begin
      // NOTE: per-voice tables are reset explicitly because a freshly reset
      // voice must be silent (gain 0) and start from phase 0.
      if (!rst_n) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            r_incr[v] <= '0;
            r_gain[v] <= '0;
         end
      end else if (cfg_we) begin
         r_incr[cfg_voice] <= cfg_incr;
         r_gain[cfg_voice] <= cfg_gain;
      end
   end

   // Frame sequencer: flush, wait for a tick, issue voices, collect results.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every term on
      // the right-hand side sees the pre-edge value, as the hardware does.
      if (!rst_n) begin
         r_state     <= S_FLUSH;
         r_flush_cnt <= '0;
         r_issue     <= '0;
         r_ret       <= '0;
         r_acc       <= '0;
         r_mix       <= '0;
         r_mix_valid <= 1'b0;
         r_done      <= 1'b0;
         r_overrun   <= 1'b0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            r_phase[v] <= '0;
         end
      end else begin
         r_mix_valid <= 1'b0;

         // A dropped tick during a frame wins over a clear in the same cycle.
         if (sample_tick && w_in_frame) begin
            r_overrun <= 1'b1;
         end else if (overrun_clr) begin
            r_overrun <= 1'b0;
         end

         if (w_accept) begin
            r_acc <= r_acc + w_prod_ext;
            r_ret <= r_ret + 1'b1;
            if (w_last) begin
               r_mix  <= r_acc + w_prod_ext;
               r_done <= 1'b1;
            end
         end

         case (r_state)
            S_FLUSH: begin
               // Let anything still inside the CORDIC pipeline drain unseen.
               if (r_flush_cnt == FW'(CORDIC_LATENCY - 1)) begin
                  r_state <= S_IDLE;
               end else begin
                  r_flush_cnt <= r_flush_cnt + 1'b1;
               end
            end
            S_IDLE: begin
               if (sample_tick) begin
                  r_state <= S_ISSUE;
                  r_issue <= '0;
                  r_ret   <= '0;
                  r_acc   <= '0;
                  r_done  <= 1'b0;
               end
            end
            S_ISSUE: begin
               r_phase[r_issue] <= w_angle;
               if (r_issue == VW'(NUM_VOICES - 1)) begin
                  r_state <= S_COLLECT;
               end else begin
                  r_issue <= r_issue + 1'b1;
               end
            end
            S_COLLECT: begin
               if (r_done) begin
                  r_mix_valid <= 1'b1;
                  r_done      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_FLUSH;
         endcase
      end
   end

endmodule
